// File: rtl/cordic_conv_pkg.sv
// Shared mode encodings and helpers for the CORDIC sign-format converter.
package cordic_conv_pkg;

  typedef logic [2:0] conv_mode_t;

  localparam conv_mode_t MODE_PASS  = 3'd0;
  localparam conv_mode_t MODE_CNEG  = 3'd1;
  localparam conv_mode_t MODE_ABS   = 3'd2;
  localparam conv_mode_t MODE_SM2TC = 3'd3;
  localparam conv_mode_t MODE_TC2SM = 3'd4;

  // x must be zero-extended from a w-bit value; true for the pattern 1 followed by zeros.
  function automatic logic is_min(input logic [31:0] x, input int w);
    return x == (32'd1 << (w - 1));
  endfunction

endpackage

// File: rtl/cordic_cond_inc.sv
// Parametrised incrementer with carry-in and carry-out; completes the ~x + 1 negation.
module cordic_cond_inc #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  assign {cout_o, sum_o} = {1'b0, a_i} + {{WIDTH{1'b0}}, cin_i};

endmodule

// File: rtl/cordic_sign_conv_pipe.sv
// Two-stage sign-format converter (negate / abs / SM<->TC) with valid/ready on both sides.
// Optional saturation of overflowing results when CORDIC_CONV_SAT_EN is defined.
module cordic_sign_conv_pipe
  import cordic_conv_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       in_mode,
  input  logic             in_flag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sign,
  output logic             out_ovf
);

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_opnd_q, s1_opnd_d;
  logic             s1_cin_q, s1_cin_d;
  logic             s1_sign_q, s1_sign_d;
  logic             s1_tc2sm_q, s1_tc2sm_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_data_q, s2_data_d;
  logic             s2_sign_q, s2_sign_d;
  logic             s2_ovf_q, s2_ovf_d;

  logic             s2_adv, accept;
  logic             st1_neg, st1_sign, st1_tc2sm;
  logic [WIDTH-1:0] st1_opnd;
  logic [WIDTH-1:0] inc_sum;
  logic             inc_cout;
  logic             st2_ovf;
  logic [WIDTH-1:0] st2_res;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign in_ready = rst_n && (!s1_valid_q || s2_adv);
  assign accept   = in_valid && in_ready;

  // Stage 1: decide whether to negate and register the inverted operand plus carry-in.
  always_comb begin
    st1_neg   = 1'b0;
    st1_opnd  = in_data;
    st1_sign  = in_data[WIDTH-1];
    st1_tc2sm = 1'b0;
    case (in_mode)
      MODE_CNEG:  st1_neg = in_flag;
      MODE_ABS:   st1_neg = in_data[WIDTH-1];
      MODE_SM2TC: begin
        st1_opnd = {1'b0, in_data[WIDTH-2:0]};
        // negative zero maps straight to 0
        st1_neg  = in_data[WIDTH-1] && !is_min(32'(in_data), WIDTH);
      end
      MODE_TC2SM: begin
        st1_neg   = in_data[WIDTH-1];
        st1_tc2sm = 1'b1;
      end
      default:    st1_sign = 1'b0;
    endcase
  end

  cordic_cond_inc #(.WIDTH(WIDTH)) u_inc (
    .a_i    (s1_opnd_q),
    .cin_i  (s1_cin_q),
    .sum_o  (inc_sum),
    .cout_o (inc_cout)
  );

  // Only MIN negates to itself; a carry-out means the operand was 0, never an overflow.
  assign st2_ovf = s1_cin_q && !inc_cout && is_min(32'(inc_sum), WIDTH);

  always_comb begin
    st2_res = s1_tc2sm_q ? {s1_sign_q, inc_sum[WIDTH-2:0]} : inc_sum;
`ifdef CORDIC_CONV_SAT_EN
    if (st2_ovf) begin
      st2_res = {s1_tc2sm_q, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_opnd_d  = s1_opnd_q;
    s1_cin_d   = s1_cin_q;
    s1_sign_d  = s1_sign_q;
    s1_tc2sm_d = s1_tc2sm_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_sign_d  = s2_sign_q;
    s2_ovf_d   = s2_ovf_q;

    if (s2_adv) begin
      s1_valid_d = 1'b0;
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = st2_res;
        s2_sign_d = s1_sign_q;
        s2_ovf_d  = st2_ovf;
      end
    end

    if (accept) begin
      s1_valid_d = 1'b1;
      s1_opnd_d  = st1_neg ? ~st1_opnd : st1_opnd;
      s1_cin_d   = st1_neg;
      s1_sign_d  = st1_sign;
      s1_tc2sm_d = st1_tc2sm;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_opnd_q  <= '0;
      s1_cin_q   <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_tc2sm_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_sign_q  <= 1'b0;
      s2_ovf_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_opnd_q  <= s1_opnd_d;
      s1_cin_q   <= s1_cin_d;
      s1_sign_q  <= s1_sign_d;
      s1_tc2sm_q <= s1_tc2sm_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_sign_q  <= s2_sign_d;
      s2_ovf_q   <= s2_ovf_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_sign  = s2_sign_q;
  assign out_ovf   = s2_ovf_q;

endmodule

// File: tb/tb_cordic_sign_conv_pipe.sv
// Bench for cordic_sign_conv_pipe at WIDTH = 8: directed vector table, random stalled stream, reset flush.
module tb_cordic_sign_conv_pipe;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [2:0]   in_mode;
  logic         in_flag;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_sign;
  logic         out_ovf;

  cordic_sign_conv_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .in_flag   (in_flag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sign  (out_sign),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    logic         sign;
    logic         ovf;
    int           acc_cyc;
    bit           lat;
  } exp_t;

  typedef struct {
    logic [2:0]   mode;
    logic         flag;
    logic [W-1:0] din;
    logic [W-1:0] dout;
    logic         sign;
    logic         ovf;
  } vec_t;

  exp_t         sbq[$];
  exp_t         cur_exp;
  vec_t         vecs[14];
  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;
  bit           prev_stall = 1'b0;
  logic [W+1:0] prev_word;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Independent arithmetic model of the converter for WIDTH = 8.
  function automatic exp_t model(input logic [2:0] mode, input logic flag, input logic [W-1:0] din);
    exp_t e;
    int   v, mag;
    logic [W-1:0] r;
    v   = din[W-1] ? int'(din) - 256 : int'(din);
    mag = int'(din[W-2:0]);
    e.sign = din[W-1];
    e.ovf  = 1'b0;
    r = din;
    case (mode)
      3'd1: if (flag) begin r = 8'(-v); e.ovf = (v == -128); end
      3'd2: begin r = 8'((v < 0) ? -v : v); e.ovf = (v == -128); end
      3'd3: r = 8'(din[W-1] ? -mag : mag);
      3'd4: begin r = 8'((v < 0) ? -v : v); r[W-1] = din[W-1]; e.ovf = (v == -128); end
      default: e.sign = 1'b0;
    endcase
`ifdef CORDIC_CONV_SAT_EN
    if (e.ovf) r = (mode == 3'd4) ? 8'hFF : 8'h7F;
`endif
    e.data    = r;
    e.acc_cyc = 0;
    e.lat     = 1'b0;
    return e;
  endfunction

  // Scoreboard: push on accept, pop and compare on emit, check hold while stalled.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sbq.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid_hold", 32'(out_valid), 32'd1);
        chk("stall_data_hold", 32'({out_data, out_sign, out_ovf}), 32'(prev_word));
      end
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_beat: got data 0x%0h with no beat outstanding (cycle %0d)", out_data, cyc);
        end else begin
          e = sbq.pop_front();
          chk("out_data", 32'(out_data), 32'(e.data));
          chk("out_sign", 32'(out_sign), 32'(e.sign));
          chk("out_ovf", 32'(out_ovf), 32'(e.ovf));
          if (e.lat) chk("latency", 32'(cyc - e.acc_cyc), 32'd2);
        end
      end
      if (in_valid && in_ready) begin
        e = cur_exp;
        e.acc_cyc = cyc;
        sbq.push_back(e);
      end
      prev_stall = out_valid && !out_ready;
      prev_word  = {out_data, out_sign, out_ovf};
    end
  end

  task automatic drive(input logic [2:0] mode, input logic flag, input logic [W-1:0] din, input exp_t e);
    in_valid = 1'b1;
    in_mode  = mode;
    in_flag  = flag;
    in_data  = din;
    cur_exp  = e;
  endtask

  task automatic drain(input string nm, input bit rnd);
    int n = 0;
    while (sbq.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL %s: %0d beats never emitted, expected 0 outstanding", nm, sbq.size());
      sbq.delete();
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
  endtask

  initial begin
    exp_t e;
    bit   acc;
    int   n;

    vecs[0]  = '{3'd1, 1'b1, 8'h05, 8'hFB, 1'b0, 1'b0};
    vecs[1]  = '{3'd1, 1'b0, 8'h05, 8'h05, 1'b0, 1'b0};
`ifdef CORDIC_CONV_SAT_EN
    vecs[2]  = '{3'd2, 1'b0, 8'h80, 8'h7F, 1'b1, 1'b1};
    vecs[7]  = '{3'd1, 1'b1, 8'h80, 8'h7F, 1'b1, 1'b1};
    vecs[8]  = '{3'd4, 1'b0, 8'h80, 8'hFF, 1'b1, 1'b1};
`else
    vecs[2]  = '{3'd2, 1'b0, 8'h80, 8'h80, 1'b1, 1'b1};
    vecs[7]  = '{3'd1, 1'b1, 8'h80, 8'h80, 1'b1, 1'b1};
    vecs[8]  = '{3'd4, 1'b0, 8'h80, 8'h80, 1'b1, 1'b1};
`endif
    vecs[3]  = '{3'd3, 1'b0, 8'h83, 8'hFD, 1'b1, 1'b0};
    vecs[4]  = '{3'd3, 1'b0, 8'h80, 8'h00, 1'b1, 1'b0};
    vecs[5]  = '{3'd4, 1'b0, 8'hFD, 8'h83, 1'b1, 1'b0};
    vecs[6]  = '{3'd7, 1'b0, 8'h80, 8'h80, 1'b0, 1'b0};
    vecs[9]  = '{3'd4, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[10] = '{3'd0, 1'b1, 8'h9A, 8'h9A, 1'b0, 1'b0};
    vecs[11] = '{3'd2, 1'b0, 8'hF0, 8'h10, 1'b1, 1'b0};
    vecs[12] = '{3'd1, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[13] = '{3'd3, 1'b0, 8'h05, 8'h05, 1'b0, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mode   = 3'd0;
    in_flag   = 1'b0;
    out_ready = 1'b1;
    cur_exp   = '{default: '0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_data", 32'({out_data, out_sign, out_ovf}), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("release_in_ready", 32'(in_ready), 32'd1);

    // Directed table, back-to-back with out_ready held high.
    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      e = '{vecs[i].dout, vecs[i].sign, vecs[i].ovf, 0, 1'b1};
      drive(vecs[i].mode, vecs[i].flag, vecs[i].din, e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain("table_drain", 1'b0);

    // Random stream with out_ready toggling.
    for (int i = 0; i < 10; i++) begin
      logic [2:0]   m;
      logic         f;
      logic [W-1:0] d;
      m = 3'($urandom_range(0, 7));
      f = 1'($urandom_range(0, 1));
      d = (i == 3) ? 8'h80 : 8'($urandom);
      drive(m, f, d, model(m, f, d));
      n = 0;
      acc = 1'b0;
      while (!acc && n < 50) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        #1;
        out_ready = 1'($urandom_range(0, 1));
        n++;
      end
      checks++;
      if (!acc) begin
        failures++;
        $display("FAIL rand_accept: beat %0d not accepted, expected acceptance within 50 cycles", i);
      end
      in_valid = 1'b0;
      if ($urandom_range(0, 2) == 0) @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    drain("rand_drain", 1'b1);

    // Fill both stages under backpressure, then reset mid-stream.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    drive(3'd2, 1'b0, 8'h83, model(3'd2, 1'b0, 8'h83));
    @(posedge clk);
    #1;
    drive(3'd1, 1'b1, 8'h05, model(3'd1, 1'b1, 8'h05));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_out_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_outputs", 32'({out_data, out_sign, out_ovf}), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("midrst_release_ready", 32'(in_ready), 32'd1);
    repeat (4) @(negedge clk);
    chk("midrst_no_stale_beat", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
